// File: rtl/axi_wb_pkg.sv
// Shared definitions for the AXI-to-Wishbone converter.
// Contents:
//   - WB_AW_DEF / WB_DW_DEF : default WB address and data widths, shared with the bridges.
//   - arb_state_t           : bus-ownership state of the read/write arbiter.
//   - WB_ARB_A / WB_ARB_B   : grant encodings, as stored in the arbiter's last-winner flag.
package axi_wb_pkg;

    localparam int WB_AW_DEF = 28;
    localparam int WB_DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic WB_ARB_A = 1'b0;
    localparam logic WB_ARB_B = 1'b1;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Ack watchdog for the WB read/write arbiter.
// It tracks the number of requests still waiting for an ack on the current
// owner's cycle. It raises `timeout` once that owner has waited
// TIMEOUT_CYCLES consecutive cycles with requests outstanding and no ack or err.
// Ports:
//   i_axi_clk, w_reset : clock and synchronous active-high reset.
//   active             : the current owner is holding CYC. When low, both counters clear.
//   req                : a strobe was forwarded and accepted (stb & !stall).
//   ack, err           : bus responses for the current owner.
//   timeout            : high during the cycle the limit is reached.
//                        The counters clear on the following edge.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_axi_clk,
    input  logic w_reset,
    input  logic active,
    input  logic req,
    input  logic ack,
    input  logic err,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] idle_cnt;

    assign timeout = (idle_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge i_axi_clk) begin
        if (w_reset || !active || timeout) begin
            outstanding <= '0;
            idle_cnt    <= '0;
        end else begin
            case ({req, ack})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            // Any response restarts the wait. The counter also restarts
            // when nothing is outstanding.
            if (outstanding != '0 && !ack && !err)
                idle_cnt <= idle_cnt + CW'(1);
            else
                idle_cnt <= '0;
        end
    end

endmodule

// File: rtl/wb_rdwr_arbiter.sv
// Shares one pipelined Wishbone master port between the AXI read bridge
// (port A) and the AXI write bridge (port B).
// Ownership is granted per WB cycle: a grant lasts as long as the owner holds CYC.
// When both sides request, the grant alternates round-robin.
// Only the owner sees ack, err and stall from the bus.
// The non-owner sees stall=1, ack=0 and err=0.
// Ports:
//   i_axi_clk, w_reset          : clock and synchronous active-high reset.
//   i_a_* / o_a_*               : read-bridge WB request and responses.
//                                 o_a_data is the bus read data.
//   i_b_* / o_b_*               : write-bridge WB request and responses.
//   o_wb_* / i_wb_*             : shared downstream WB master port.
// Build option WB_ARB_TIMEOUT_EN adds an ack watchdog (wb_arb_watchdog).
// When it fires, it errors the owner, forces CYC low and returns the arbiter to IDLE.
module wb_rdwr_arbiter
    import axi_wb_pkg::*;
#(
    parameter int AW             = WB_AW_DEF,
    parameter int DW             = WB_DW_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            i_axi_clk,
    input  logic            w_reset,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_ack,
    output logic            o_a_stall,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_ack,
    output logic            o_b_stall,
    output logic            o_b_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    arb_state_t state;
    logic       last_b;
    logic       timeout;
    logic       own_a, own_b;

    assign own_a = (state == OWN_A);
    assign own_b = (state == OWN_B);

`ifdef WB_ARB_TIMEOUT_EN
    logic own_cyc, own_stb;
    assign own_cyc = (own_a && i_a_cyc) || (own_b && i_b_cyc);
    assign own_stb = (own_a && i_a_stb) || (own_b && i_b_stb);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_axi_clk (i_axi_clk),
        .w_reset   (w_reset),
        .active    (own_cyc),
        .req       (own_stb && !i_wb_stall),
        .ack       (i_wb_ack),
        .err       (i_wb_err),
        .timeout   (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
    assign timeout            = 1'b0;
`endif

    // Arbitration. A grant is only decided from IDLE or on the owner's CYC release.
    // An active CYC is never pre-empted.
    always_ff @(posedge i_axi_clk) begin
        if (w_reset) begin
            state  <= IDLE;
            last_b <= WB_ARB_B;
        end else if (timeout) begin
            state  <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_a_cyc && (!i_b_cyc || last_b == WB_ARB_B)) begin
                        state  <= OWN_A;
                        last_b <= WB_ARB_A;
                    end else if (i_b_cyc) begin
                        state  <= OWN_B;
                        last_b <= WB_ARB_B;
                    end
                end
                // On release, hand straight over to a waiting other side.
                // That avoids an idle cycle on the bus.
                OWN_A: begin
                    if (!i_a_cyc) begin
                        if (i_b_cyc) begin
                            state  <= OWN_B;
                            last_b <= WB_ARB_B;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                OWN_B: begin
                    if (!i_b_cyc) begin
                        if (i_a_cyc) begin
                            state  <= OWN_A;
                            last_b <= WB_ARB_A;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_a_data = i_wb_data;

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        o_a_ack   = 1'b0;
        o_a_stall = 1'b1;
        o_a_err   = 1'b0;
        o_b_ack   = 1'b0;
        o_b_stall = 1'b1;
        o_b_err   = 1'b0;
        if (own_a) begin
            o_wb_cyc  = i_a_cyc && !timeout;
            o_wb_stb  = i_a_stb && !timeout;
            o_a_ack   = i_wb_ack;
            o_a_stall = i_wb_stall;
            o_a_err   = i_wb_err || timeout;
        end else if (own_b) begin
            o_wb_cyc  = i_b_cyc && !timeout;
            o_wb_stb  = i_b_stb && !timeout;
            o_wb_we   = i_b_we;
            o_wb_addr = i_b_addr;
            o_wb_data = i_b_data;
            o_wb_sel  = i_b_sel;
            o_b_ack   = i_wb_ack;
            o_b_stall = i_wb_stall;
            o_b_err   = i_wb_err || timeout;
        end
    end

endmodule

// File: tb/tb_wb_rdwr_arbiter.sv
// Testbench for wb_rdwr_arbiter.
// Each cycle is one stimulus row. The row gives the bus inputs and the hand-derived owner for that cycle.
// model() turns the row into the expected outputs.
// run_vec() pushes that expectation into a scoreboard queue when it drives the row.
// The expectation is popped and compared on the falling edge.
// The watchdog sequence at the end also covers WB_ARB_TIMEOUT_EN builds.
module tb_wb_rdwr_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;

    typedef struct packed {
        logic          rst;
        logic          ac, as;
        logic [AW-1:0] aa;
        logic          bc, bs;
        logic [AW-1:0] ba;
        logic          ack, stall, err;
        logic [1:0]    own;   // 0 = none, 1 = A, 2 = B
        logic [DW-1:0] rd;
    } vec_t;

    typedef struct packed {
        logic          cyc, stb, a_ack, a_stall, a_err, b_ack, b_stall, b_err;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    sel;
        logic [DW-1:0] rdata;
        logic          mchk;
    } out_t;

    logic i_axi_clk = 1'b0;
    logic w_reset;
    logic i_a_cyc, i_a_stb, i_a_we, i_b_cyc, i_b_stb, i_b_we;
    logic [AW-1:0] i_a_addr, i_b_addr;
    logic [DW-1:0] i_a_data, i_b_data, i_wb_data;
    logic [3:0] i_a_sel, i_b_sel;
    logic o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
    logic [DW-1:0] o_a_data;
    logic o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [3:0] o_wb_sel;
    logic i_wb_ack, i_wb_stall, i_wb_err;

    always #5 i_axi_clk = ~i_axi_clk;

    wb_rdwr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .i_axi_clk(i_axi_clk), .w_reset(w_reset),
        .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
        .i_a_data(i_a_data), .i_a_sel(i_a_sel),
        .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err), .o_a_data(o_a_data),
        .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
        .i_b_data(i_b_data), .i_b_sel(i_b_sel),
        .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    out_t sbq[$];

    function automatic vec_t mv(logic rst, logic ac, logic as, logic [AW-1:0] aa,
                                logic bc, logic bs, logic [AW-1:0] ba,
                                logic ack, logic stall, logic err, logic [1:0] own);
        vec_t v;
        v.rst = rst; v.ac = ac; v.as = as; v.aa = aa;
        v.bc = bc; v.bs = bs; v.ba = ba;
        v.ack = ack; v.stall = stall; v.err = err; v.own = own;
        v.rd = '0;
        return v;
    endfunction

    // Side A always drives we=0 and sel=3. Side B always drives we=1 and sel=C.
    // Each side's write data is tagged with its own nibble, so a mux slip shows up.
    function automatic out_t model(vec_t v);
        out_t e;
        e = '0;
        e.a_stall = 1'b1;
        e.b_stall = 1'b1;
        e.rdata   = v.rd;
        if (v.own == 2'd1) begin
            e.cyc = v.ac; e.stb = v.as; e.we = 1'b0; e.addr = v.aa;
            e.data = {4'hA, v.aa}; e.sel = 4'h3;
            e.a_ack = v.ack; e.a_stall = v.stall; e.a_err = v.err;
            e.mchk = 1'b1;
        end else if (v.own == 2'd2) begin
            e.cyc = v.bc; e.stb = v.bs; e.we = 1'b1; e.addr = v.ba;
            e.data = {4'hB, v.ba}; e.sel = 4'hC;
            e.b_ack = v.ack; e.b_stall = v.stall; e.b_err = v.err;
            e.mchk = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input vec_t v);
        w_reset = v.rst;
        i_a_cyc = v.ac; i_a_stb = v.as; i_a_we = 1'b0; i_a_addr = v.aa;
        i_a_data = {4'hA, v.aa}; i_a_sel = 4'h3;
        i_b_cyc = v.bc; i_b_stb = v.bs; i_b_we = 1'b1; i_b_addr = v.ba;
        i_b_data = {4'hB, v.ba}; i_b_sel = 4'hC;
        i_wb_ack = v.ack; i_wb_stall = v.stall; i_wb_err = v.err; i_wb_data = v.rd;
    endtask

    task automatic check(input string name);
        out_t e, g;
        bit   ok;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sbq.pop_front();
        g = '0;
        g.cyc = o_wb_cyc; g.stb = o_wb_stb;
        g.a_ack = o_a_ack; g.a_stall = o_a_stall; g.a_err = o_a_err;
        g.b_ack = o_b_ack; g.b_stall = o_b_stall; g.b_err = o_b_err;
        g.we = o_wb_we; g.addr = o_wb_addr; g.data = o_wb_data; g.sel = o_wb_sel;
        g.rdata = o_a_data; g.mchk = e.mchk;
        n_vec++;
        ok = ({g.cyc, g.stb, g.a_ack, g.a_stall, g.a_err, g.b_ack, g.b_stall, g.b_err, g.rdata} ===
              {e.cyc, e.stb, e.a_ack, e.a_stall, e.a_err, e.b_ack, e.b_stall, e.b_err, e.rdata});
        if (e.mchk)
            ok = ok && ({g.we, g.addr, g.data, g.sel} === {e.we, e.addr, e.data, e.sel});
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, g, e);
        end
    endtask

    // ovr: this row is the watchdog-fire cycle. The owner sees err, and the bus CYC/STB are forced low.
    task automatic run_vec(input vec_t v, input bit ovr, input string name);
        out_t e;
        @(posedge i_axi_clk);
        #1;
        drive(v);
        e = model(v);
        if (ovr) begin
            e.cyc = 1'b0; e.stb = 1'b0; e.a_err = 1'b1;
        end
        sbq.push_back(e);
        @(negedge i_axi_clk);
        check(name);
    endtask

    localparam logic [AW-1:0] A1 = 28'h0000100;
    localparam logic [AW-1:0] A2 = 28'h0000200;
    localparam logic [AW-1:0] B1 = 28'h0000300;
    localparam logic [AW-1:0] Z  = 28'h0;

    vec_t tbl[27];
    vec_t v;
    bit   to_en;

    initial begin
        //             rst ac as aa  bc bs ba  ack stl err own
        tbl[0]  = mv(1, 0, 0, Z,  0, 0, Z,  0, 0, 0, 0);  // reset state
        tbl[1]  = mv(0, 0, 0, Z,  0, 0, Z,  0, 0, 0, 0);
        tbl[2]  = mv(0, 1, 1, A1, 0, 0, Z,  0, 1, 0, 0);  // A seen, not yet granted
        tbl[3]  = mv(0, 1, 1, A1, 0, 0, Z,  0, 1, 0, 1);  // A owns, stall passes
        tbl[4]  = mv(0, 1, 1, A1, 0, 0, Z,  0, 0, 0, 1);
        tbl[5]  = mv(0, 1, 0, A1, 0, 0, Z,  1, 0, 0, 1);  // ack to A
        tbl[6]  = mv(0, 0, 0, A1, 0, 0, Z,  0, 0, 0, 1);  // A releases
        tbl[7]  = mv(1, 0, 0, Z,  0, 0, Z,  0, 0, 0, 0);  // reset restores A-first tie
        tbl[8]  = mv(0, 1, 1, A2, 1, 1, B1, 0, 0, 0, 0);  // simultaneous request
        tbl[9]  = mv(0, 1, 1, A2, 1, 1, B1, 0, 0, 0, 1);  // A wins tie
        tbl[10] = mv(0, 1, 0, A2, 1, 1, B1, 1, 0, 0, 1);  // ack only to A
        tbl[11] = mv(0, 0, 0, A2, 1, 1, B1, 0, 0, 0, 1);  // A drops, B waiting
        tbl[12] = mv(0, 1, 1, A2, 1, 1, B1, 0, 1, 0, 2);  // B owns, no gap
        tbl[13] = mv(0, 1, 1, A2, 1, 1, B1, 1, 0, 0, 2);
        tbl[14] = mv(0, 1, 1, A2, 1, 1, B1, 1, 1, 0, 2);
        tbl[15] = mv(0, 1, 1, A2, 1, 0, B1, 1, 0, 0, 2);  // A stb must not leak
        tbl[16] = mv(0, 1, 1, A2, 1, 0, B1, 1, 0, 0, 2);
        tbl[17] = mv(0, 1, 1, A2, 0, 0, B1, 0, 0, 0, 2);  // B drops, A waiting
        tbl[18] = mv(0, 1, 1, A2, 0, 0, Z,  0, 0, 1, 1);  // err only to A
        tbl[19] = mv(0, 0, 0, A2, 0, 0, Z,  0, 0, 0, 1);
        tbl[20] = mv(0, 0, 0, Z,  0, 0, Z,  1, 0, 1, 0);  // stray ack/err dropped
        tbl[21] = mv(0, 0, 0, Z,  1, 1, B1, 0, 0, 0, 0);
        tbl[22] = mv(0, 0, 0, Z,  1, 1, B1, 0, 0, 0, 2);
        tbl[23] = mv(0, 0, 0, Z,  1, 1, B1, 0, 0, 0, 2);  // 2 outstanding
        tbl[24] = mv(1, 0, 0, Z,  1, 0, B1, 0, 0, 0, 2);  // reset mid-cycle
        tbl[25] = mv(0, 0, 0, Z,  0, 0, B1, 1, 0, 0, 0);  // late ack dropped
        tbl[26] = mv(0, 0, 0, Z,  0, 0, Z,  1, 0, 0, 0);

        drive(mv(1, 0, 0, Z, 0, 0, Z, 0, 0, 0, 0));
        repeat (2) @(posedge i_axi_clk);

        for (int i = 0; i < 27; i++) begin
            v    = tbl[i];
            v.rd = 32'hC000_0000 + 32'(i);
            run_vec(v, 1'b0, $sformatf("vec%0d", i));
        end

        // Watchdog: a single accepted strobe, then no ack.
`ifdef WB_ARB_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        run_vec(mv(0, 1, 1, A1, 0, 0, Z, 0, 0, 0, 0), 1'b0, "wd_req");
        run_vec(mv(0, 1, 1, A1, 0, 0, Z, 0, 0, 0, 1), 1'b0, "wd_stb");
        for (int k = 0; k < 8; k++)
            run_vec(mv(0, 1, 0, A1, 0, 0, Z, 0, 0, 0, 1), 1'b0, $sformatf("wd_wait%0d", k));
        run_vec(mv(0, 1, 0, A1, 0, 0, Z, 0, 0, 0, 1), to_en, "wd_fire");
        run_vec(mv(0, 0, 0, A1, 0, 0, Z, 0, 0, 0, to_en ? 2'd0 : 2'd1), 1'b0, "wd_after");
        run_vec(mv(0, 0, 0, Z, 0, 0, Z, 0, 0, 0, 0), 1'b0, "wd_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
